rv_decode_stage: RTL and testbench

- Parametrised RV32I decode stage between the fetch (ID_STATE) and execute (EX_STATE) pipeline registers.
- Decodes all RV32I base opcodes and generates I/S/B/U/J immediates sign-extended to XLEN.
- Provides control signals, illegal-instruction flagging, valid/ready backpressure, flush, load-use hazard stall and a saturating stall-cycle counter.

---
 rtl/rv_decode_stage_if.sv | 47 ++++
 rtl/rv_decode_stage.sv | 211 +++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_if.sv
// Bundle of fetch-side, EX-side and decoded-output signals around the RV32I decode stage.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface rv_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic              flush;
    logic              ex_load_valid;
    logic [4:0]        ex_load_rd;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [2:0]        out_func3;
    logic [6:0]        out_func7;
    logic [XLEN-1:0]   out_imm;
    logic [1:0]        out_alu_op;
    logic              out_alu_src;
    logic              out_mem_read;
    logic              out_mem_write;
    logic              out_reg_write;
    logic              out_branch;
    logic              out_jump;
    logic              out_illegal;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_pc, in_instr, flush, ex_load_valid, ex_load_rd, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_func3, out_func7,
               out_imm, out_alu_op, out_alu_src, out_mem_read, out_mem_write,
               out_reg_write, out_branch, out_jump, out_illegal, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, ex_load_valid, ex_load_rd, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_func3, out_func7,
               out_imm, out_alu_op, out_alu_src, out_mem_read, out_mem_write,
               out_reg_write, out_branch, out_jump, out_illegal, stall_cnt
    );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: one-cycle registered decode with valid/ready backpressure,
// flush, load-use hazard stall and a saturating stall-cycle counter.
module rv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    rv_decode_stage_if.slave bus
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [XLEN-1:0] imm;
        logic [1:0]      alu_op;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            branch;
        logic            jump;
        logic            illegal;
    } bundle_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    bundle_t          bundle_q, bundle_d, dec;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             rs1_used, rs2_used, hazard, in_ready, accept;

    logic [31:0] instr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] shamt;

    assign instr = bus.in_instr;
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        shamt = '0;
        if (XLEN == 64) shamt[5:0] = instr[25:20];
        else            shamt[4:0] = instr[24:20];
    end

    always_comb begin
        dec       = '0;
        dec.pc    = bus.in_pc;
        dec.rd    = instr[11:7];
        dec.rs1   = instr[19:15];
        dec.rs2   = instr[24:20];
        dec.func3 = instr[14:12];
        dec.func7 = instr[31:25];
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        case (instr[6:0])
            OP_R: begin
                dec.alu_op    = 2'b10;
                dec.reg_write = 1'b1;
                rs2_used      = 1'b1;
                dec.illegal   = (dec.func7 != 7'b0000000) && (dec.func7 != 7'b0100000);
            end
            OP_IMM: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = (dec.func3 == 3'b001 || dec.func3 == 3'b101) ? shamt : sext32(imm_i);
            end
            OP_LOAD: begin
                dec.mem_read  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = sext32(imm_i);
                dec.illegal   = (dec.func3 == 3'b011) || (dec.func3 == 3'b110) || (dec.func3 == 3'b111);
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = sext32(imm_s);
                rs2_used      = 1'b1;
                dec.illegal   = dec.func3 > 3'b010;
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.alu_op  = 2'b01;
                dec.imm     = sext32(imm_b);
                rs2_used    = 1'b1;
                dec.illegal = (dec.func3 == 3'b010) || (dec.func3 == 3'b011);
            end
            OP_LUI, OP_AUIPC: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = sext32(imm_u);
                rs1_used      = 1'b0;
            end
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = sext32(imm_j);
                rs1_used      = 1'b0;
            end
            OP_JALR: begin
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = sext32(imm_i);
            end
            OP_FENCE, OP_SYSTEM: dec.imm = sext32(imm_i);
            default:             dec.illegal = 1'b1;
        endcase
        // Illegal encodings still go downstream so EX can raise the trap, but must not side-effect.
        if (dec.illegal) begin
            dec.alu_op    = 2'b00;
            dec.alu_src   = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.reg_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

    assign hazard = bus.in_valid && bus.ex_load_valid && (bus.ex_load_rd != 5'd0) &&
                    ((rs1_used && dec.rs1 == bus.ex_load_rd) ||
                     (rs2_used && dec.rs2 == bus.ex_load_rd));

    assign in_ready = reset && (bus.flush || ((!out_valid_q || bus.out_ready) && !hazard));
    assign accept   = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else begin
            if (accept) begin
                bundle_d    = dec;
                out_valid_d = 1'b1;
            end else if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            if (hazard && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_pc        = bundle_q.pc;
    assign bus.out_rd        = bundle_q.rd;
    assign bus.out_rs1       = bundle_q.rs1;
    assign bus.out_rs2       = bundle_q.rs2;
    assign bus.out_func3     = bundle_q.func3;
    assign bus.out_func7     = bundle_q.func7;
    assign bus.out_imm       = bundle_q.imm;
    assign bus.out_alu_op    = bundle_q.alu_op;
    assign bus.out_alu_src   = bundle_q.alu_src;
    assign bus.out_mem_read  = bundle_q.mem_read;
    assign bus.out_mem_write = bundle_q.mem_write;
    assign bus.out_reg_write = bundle_q.reg_write;
    assign bus.out_branch    = bundle_q.branch;
    assign bus.out_jump      = bundle_q.jump;
    assign bus.out_illegal   = bundle_q.illegal;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: a 32-bit instance plus a 64-bit instance with a
// 2-bit stall counter driven by the same inputs, to cover wide immediates and saturation.
module tb_rv_decode_stage;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    rv_decode_stage_if #(.XLEN(32), .PC_W(32), .CNT_W(16)) bus ();
    rv_decode_stage_if #(.XLEN(64), .PC_W(32), .CNT_W(2))  bus64 ();

    rv_decode_stage #(.XLEN(32), .PC_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    rv_decode_stage #(.XLEN(64), .PC_W(32), .CNT_W(2)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64.slave)
    );

    assign bus64.in_valid      = bus.in_valid;
    assign bus64.in_pc         = bus.in_pc;
    assign bus64.in_instr      = bus.in_instr;
    assign bus64.flush         = bus.flush;
    assign bus64.ex_load_valid = bus.ex_load_valid;
    assign bus64.ex_load_rd    = bus.ex_load_rd;
    assign bus64.out_ready     = bus.out_ready;

    localparam logic [31:0] I_ADD   = 32'h002081B3;  // add  x3,x1,x2
    localparam logic [31:0] I_ADDI  = 32'hFFF00093;  // addi x1,x0,-1
    localparam logic [31:0] I_SW    = 32'h0020A423;  // sw   x2,8(x1)
    localparam logic [31:0] I_BEQ   = 32'hFE208EE3;  // beq  x1,x2,-4
    localparam logic [31:0] I_LUI   = 32'h123452B7;  // lui  x5,0x12345
    localparam logic [31:0] I_JAL   = 32'hFF9FF0EF;  // jal  x1,-8
    localparam logic [31:0] I_SRAI  = 32'h40335293;  // srai x5,x6,3
    localparam logic [31:0] I_MUL   = 32'h022081B3;  // R-type with func7=0000001
    localparam logic [31:0] I_ZERO  = 32'h00000000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = instr;
    endtask

    task automatic check_ctrl(input string tag, input logic [1:0] alu_op, input logic alu_src,
                              input logic mem_read, input logic mem_write, input logic reg_write,
                              input logic branch, input logic jump, input logic illegal);
        check({tag, ".alu_op"},    bus.out_alu_op,    alu_op);
        check({tag, ".alu_src"},   bus.out_alu_src,   alu_src);
        check({tag, ".mem_read"},  bus.out_mem_read,  mem_read);
        check({tag, ".mem_write"}, bus.out_mem_write, mem_write);
        check({tag, ".reg_write"}, bus.out_reg_write, reg_write);
        check({tag, ".branch"},    bus.out_branch,    branch);
        check({tag, ".jump"},      bus.out_jump,      jump);
        check({tag, ".illegal"},   bus.out_illegal,   illegal);
    endtask

    initial begin
        reset             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_pc         = '0;
        bus.in_instr      = '0;
        bus.flush         = 1'b0;
        bus.ex_load_valid = 1'b0;
        bus.ex_load_rd    = '0;
        bus.out_ready     = 1'b0;
        #1;
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.in_ready",  bus.in_ready,  0);
        check("rst.stall_cnt", bus.stall_cnt, 0);
        check("rst.out_imm",   bus.out_imm,   0);
        tick();
        tick();
        reset = 1'b1;

        // Decode table, one instruction per cycle with EX always ready.
        bus.out_ready = 1'b1;
        drive(32'h100, I_ADD);
        #1 check("add.in_ready", bus.in_ready, 1);
        tick();
        check("add.out_valid", bus.out_valid, 1);
        check("add.pc",  bus.out_pc,  32'h100);
        check("add.rd",  bus.out_rd,  3);
        check("add.rs1", bus.out_rs1, 1);
        check("add.rs2", bus.out_rs2, 2);
        check_ctrl("add", 2'b10, 0, 0, 0, 1, 0, 0, 0);

        drive(32'h104, I_ADDI);
        tick();
        check("addi.imm",   bus.out_imm,   32'hFFFFFFFF);
        check("addi64.imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFFF);
        check_ctrl("addi", 2'b11, 1, 0, 0, 1, 0, 0, 0);

        drive(32'h108, I_SW);
        tick();
        check("sw.imm", bus.out_imm, 8);
        check_ctrl("sw", 2'b00, 1, 0, 1, 0, 0, 0, 0);

        drive(32'h10C, I_BEQ);
        tick();
        check("beq.imm",   bus.out_imm,   32'hFFFFFFFC);
        check("beq64.imm", bus64.out_imm, 64'hFFFFFFFFFFFFFFFC);
        check_ctrl("beq", 2'b01, 0, 0, 0, 0, 1, 0, 0);

        drive(32'h110, I_LUI);
        tick();
        check("lui.rd",    bus.out_rd,    5);
        check("lui.imm",   bus.out_imm,   32'h12345000);
        check("lui64.imm", bus64.out_imm, 64'h0000000012345000);
        check_ctrl("lui", 2'b00, 1, 0, 0, 1, 0, 0, 0);

        drive(32'h114, I_JAL);
        tick();
        check("jal.imm", bus.out_imm, 32'hFFFFFFF8);
        check_ctrl("jal", 2'b00, 0, 0, 0, 1, 0, 1, 0);

        drive(32'h118, I_SRAI);
        tick();
        check("srai.imm",   bus.out_imm,   3);
        check("srai.func7", bus.out_func7, 7'h20);
        check("srai.func3", bus.out_func3, 3'b101);
        check_ctrl("srai", 2'b11, 1, 0, 0, 1, 0, 0, 0);

        drive(32'h11C, I_MUL);
        tick();
        check("mul.out_valid", bus.out_valid, 1);
        check_ctrl("mul", 2'b00, 0, 0, 0, 0, 0, 0, 1);

        drive(32'h120, I_ZERO);
        tick();
        check("zero.out_valid", bus.out_valid, 1);
        check_ctrl("zero", 2'b00, 0, 0, 0, 0, 0, 0, 1);

        // Backpressure: EX stalls for three cycles while fetch keeps offering.
        drive(32'h200, I_ADD);
        tick();
        check("bp.first_pc", bus.out_pc, 32'h200);
        bus.out_ready = 1'b0;
        drive(32'h204, I_ADDI);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp.in_ready", bus.in_ready, 0);
            tick();
            check("bp.out_valid", bus.out_valid, 1);
            check("bp.out_pc",    bus.out_pc,    32'h200);
            check("bp.out_rd",    bus.out_rd,    3);
            check("bp.out_imm",   bus.out_imm,   0);
        end
        bus.out_ready = 1'b1;
        #1 check("bp.release_in_ready", bus.in_ready, 1);
        tick();
        check("bp.replace_pc",    bus.out_pc,    32'h204);
        check("bp.replace_valid", bus.out_valid, 1);
        drive(32'h208, I_SW);
        tick();
        check("b2b.pc0", bus.out_pc, 32'h208);
        drive(32'h20C, I_ADD);
        tick();
        check("b2b.pc1", bus.out_pc, 32'h20C);

        // Load-use on rs1: two stalled cycles, bundle drains to a bubble.
        bus.ex_load_valid = 1'b1;
        bus.ex_load_rd    = 5'd1;
        drive(32'h300, I_ADD);
        #1 check("lu.in_ready", bus.in_ready, 0);
        tick();
        check("lu.bubble",  bus.out_valid, 0);
        check("lu.cnt1",    bus.stall_cnt, 1);
        check("lu.in_ready2", bus.in_ready, 0);
        tick();
        check("lu.cnt2",    bus.stall_cnt, 2);
        check("lu.still_bubble", bus.out_valid, 0);
        bus.ex_load_valid = 1'b0;
        #1 check("lu.release", bus.in_ready, 1);
        tick();
        check("lu.accept_pc", bus.out_pc,    32'h300);
        check("lu.accept_v",  bus.out_valid, 1);
        check("lu.cnt_hold",  bus.stall_cnt, 2);

        // Load into x0 never stalls.
        bus.ex_load_valid = 1'b1;
        bus.ex_load_rd    = 5'd0;
        drive(32'h304, I_ADD);
        #1 check("x0.in_ready", bus.in_ready, 1);
        tick();
        check("x0.pc",  bus.out_pc,    32'h304);
        check("x0.cnt", bus.stall_cnt, 2);

        // Load-use through rs2 of a store; 64-bit instance has a 2-bit counter that saturates.
        bus.ex_load_rd = 5'd2;
        drive(32'h308, I_SW);
        for (int i = 0; i < 3; i++) tick();
        check("sat.cnt32", bus.stall_cnt,   5);
        check("sat.cnt64", bus64.stall_cnt, 3);
        check("sat.in_ready", bus.in_ready, 0);

        // LUI's rs1 field (x8) matching the load must not stall.
        bus.ex_load_rd = 5'd8;
        drive(32'h30C, I_LUI);
        #1 check("lui_nohz.in_ready", bus.in_ready, 1);
        tick();
        check("lui_nohz.pc",  bus.out_pc,    32'h30C);
        check("lui_nohz.cnt", bus.stall_cnt, 5);

        // Flush with a held bundle and a simultaneous hazard.
        bus.out_ready     = 1'b0;
        bus.flush         = 1'b1;
        bus.ex_load_rd    = 5'd1;
        drive(32'h310, I_ADD);
        #1 check("flush.in_ready", bus.in_ready, 1);
        tick();
        check("flush.out_valid", bus.out_valid, 0);
        check("flush.cnt",       bus.stall_cnt, 5);
        bus.flush         = 1'b0;
        bus.ex_load_valid = 1'b0;
        drive(32'h400, I_ADDI);
        tick();
        check("postflush.pc", bus.out_pc, 32'h400);
        check("postflush.v",  bus.out_valid, 1);

        // Reset asserted while stalled with a held bundle.
        bus.ex_load_valid = 1'b1;
        bus.ex_load_rd    = 5'd1;
        drive(32'h404, I_ADD);
        tick();
        check("prerst.cnt", bus.stall_cnt, 6);
        check("prerst.v",   bus.out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst.out_valid", bus.out_valid,     0);
        check("midrst.stall_cnt", bus.stall_cnt,     0);
        check("midrst.cnt64",     bus64.stall_cnt,   0);
        check("midrst.out_pc",    bus.out_pc,        0);
        check("midrst.out_imm",   bus.out_imm,       0);
        check("midrst.reg_write", bus.out_reg_write, 0);
        check("midrst.in_ready",  bus.in_ready,      0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
